// File: rtl/io_ports.sv
// Invaders I/O and interrupt peripheral: IN/OUT port decode, sound latches,
// barrel-shift helper, watchdog and RST-vector interrupt controller.
module io_ports #(
  parameter int                   WDT_WIDTH = 24,
  parameter logic [WDT_WIDTH-1:0] WDT_LIMIT = 24'd2_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] status,
  input  logic [7:0] addr,
  inout  wire  [7:0] data,
  input  logic       dbin,
  input  logic       write_n,
  input  logic [7:0] in0,
  input  logic [7:0] in1,
  input  logic [7:0] in2,
  input  logic       irq_mid,
  input  logic       irq_end,
  output logic       iint,
  output logic [7:0] sound1,
  output logic [7:0] sound2,
  output logic       wdt_expired
);

  logic                 r_wr_n_q;
  logic                 r_dbin_q;
  logic                 r_pend_mid;
  logic                 r_pend_end;
  logic                 r_iint;
  logic                 r_wdt_expired;
  logic [15:0]          r_shift_data;
  logic [2:0]           r_shift_off;
  logic [7:0]           r_sound1;
  logic [7:0]           r_sound2;
  logic [WDT_WIDTH-1:0] r_wdt_cnt;

  logic        w_wr_strobe;
  logic        w_io_wr;
  logic        w_io_rd;
  logic        w_inta_rd;
  logic        w_inta_fall;
  logic        w_clr_mid;
  logic        w_clr_end;
  logic        w_port6_wr;
  logic        w_drive;
  logic [7:0]  w_rd_data;
  logic [15:0] w_shifted;
  logic        w_unused_status;

  assign w_wr_strobe = ~write_n & r_wr_n_q;
  assign w_io_wr     = w_wr_strobe & status[4];
  assign w_io_rd     = dbin & status[6] & ~status[0];
  assign w_inta_rd   = dbin & status[0];
  assign w_inta_fall = r_dbin_q & ~dbin & status[0];
  // pending_end is served first, so only it is cleared when both are set
  assign w_clr_end   = w_inta_fall & r_pend_end;
  assign w_clr_mid   = w_inta_fall & ~r_pend_end & r_pend_mid;
  assign w_port6_wr  = w_io_wr & (addr == 8'd6);
  assign w_shifted   = r_shift_data << r_shift_off;
  assign w_unused_status = &{1'b0, status[7], status[5], status[3:1]};

  // Strobe edge detectors for write_n and dbin
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_n_q <= 1'b1;
      r_dbin_q <= 1'b0;
    end else begin
      r_wr_n_q <= write_n;
      r_dbin_q <= dbin;
    end
  end

  // OUT-port latches: shifter and sound
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift_data <= 16'h0000;
      r_shift_off  <= 3'd0;
      r_sound1     <= 8'h00;
      r_sound2     <= 8'h00;
    end else if (w_io_wr) begin
      case (addr)
        8'd2:    r_shift_off  <= data[2:0];
        8'd3:    r_sound1     <= data;
        8'd4:    r_shift_data <= {data, r_shift_data[15:8]};
        8'd5:    r_sound2     <= data;
        default: r_shift_off  <= r_shift_off;
      endcase
    end else begin
      r_shift_data <= r_shift_data;
    end
  end

  // Interrupt pending flags; a new pulse beats a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_mid <= 1'b0;
      r_pend_end <= 1'b0;
      r_iint     <= 1'b0;
    end else begin
      if (irq_end) begin
        r_pend_end <= 1'b1;
      end else if (w_clr_end) begin
        r_pend_end <= 1'b0;
      end else begin
        r_pend_end <= r_pend_end;
      end
      if (irq_mid) begin
        r_pend_mid <= 1'b1;
      end else if (w_clr_mid) begin
        r_pend_mid <= 1'b0;
      end else begin
        r_pend_mid <= r_pend_mid;
      end
      r_iint <= r_pend_mid | r_pend_end;
    end
  end

  // Watchdog: free-running counter kicked by port-6 writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdt_cnt     <= '0;
      r_wdt_expired <= 1'b0;
    end else if (w_port6_wr) begin
      r_wdt_cnt     <= '0;
      r_wdt_expired <= 1'b0;
    end else if (r_wdt_cnt == WDT_LIMIT - 1'b1) begin
      r_wdt_cnt     <= '0;
      r_wdt_expired <= 1'b1;
    end else begin
      r_wdt_cnt     <= r_wdt_cnt + 1'b1;
      r_wdt_expired <= 1'b0;
    end
  end

  // Read-data mux for INTA vectors and IN ports
  always_comb begin
    w_drive   = 1'b0;
    w_rd_data = 8'h00;
    if (w_inta_rd) begin
      w_drive = 1'b1;
      if (r_pend_end) begin
        w_rd_data = 8'hD7;
      end else if (r_pend_mid) begin
        w_rd_data = 8'hCF;
      end else begin
        w_rd_data = 8'hFF;
      end
    end else if (w_io_rd) begin
      w_drive = 1'b1;
      case (addr)
        8'd0:    w_rd_data = in0;
        8'd1:    w_rd_data = in1;
        8'd2:    w_rd_data = in2;
        8'd3:    w_rd_data = w_shifted[15:8];
        default: w_rd_data = 8'h00;
      endcase
    end else begin
      w_drive   = 1'b0;
      w_rd_data = 8'h00;
    end
  end

  assign data        = (w_drive && rst_n) ? w_rd_data : 8'hzz;
  assign iint        = r_iint;
  assign sound1      = r_sound1;
  assign sound2      = r_sound2;
  assign wdt_expired = r_wdt_expired;

endmodule

// File: tb/tb_io_ports.sv
// Self-checking bench for io_ports: vector table, directed interrupt/watchdog/reset
// sequences and a randomized run against a port-level reference model.
module tb_io_ports;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] status = 8'h00;
  logic [7:0] addr = 8'h00;
  wire  [7:0] data;
  logic       dbin = 1'b0;
  logic       write_n = 1'b1;
  logic [7:0] in0 = 8'h00, in1 = 8'h00, in2 = 8'h00;
  logic       irq_mid = 1'b0, irq_end = 1'b0;
  logic       iint;
  logic [7:0] sound1, sound2;
  logic       wdt_expired;
  logic       tb_en = 1'b0;
  logic [7:0] tb_drv = 8'h00;

  int n_tests = 0;
  int n_fail  = 0;

  assign data = tb_en ? tb_drv : 8'hzz;

  io_ports #(.WDT_WIDTH(24), .WDT_LIMIT(24'd16)) dut (
    .clk(clk), .rst_n(rst_n), .status(status), .addr(addr), .data(data),
    .dbin(dbin), .write_n(write_n), .in0(in0), .in1(in1), .in2(in2),
    .irq_mid(irq_mid), .irq_end(irq_end), .iint(iint), .sound1(sound1),
    .sound2(sound2), .wdt_expired(wdt_expired)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         wr;
    logic [7:0] port;
    logic [7:0] val;
    logic [7:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    status = 8'h00; dbin = 1'b0; write_n = 1'b1; tb_en = 1'b0;
    irq_mid = 1'b0; irq_end = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic do_out(input logic [7:0] port, input logic [7:0] val, input int hold);
    @(negedge clk);
    status = 8'h10; addr = port; tb_drv = val; tb_en = 1'b1; write_n = 1'b0;
    repeat (hold) @(negedge clk);
    write_n = 1'b1; tb_en = 1'b0; status = 8'h00;
  endtask

  task automatic do_in(input logic [7:0] port, output logic [7:0] val);
    @(negedge clk);
    status = 8'h40; addr = port; dbin = 1'b1;
    #1 val = data;
    @(negedge clk);
    dbin = 1'b0; status = 8'h00;
  endtask

  // INTA read; optionally pulse irq_mid in the cycle dbin falls
  task automatic do_inta(output logic [7:0] val, input bit mid_at_fall);
    @(negedge clk);
    status = 8'h01; dbin = 1'b1;
    #1 val = data;
    @(negedge clk);
    dbin = 1'b0; irq_mid = mid_at_fall;
    @(negedge clk);
    irq_mid = 1'b0; status = 8'h00;
  endtask

  task automatic pulse_irq(input bit m, input bit e);
    @(negedge clk);
    irq_mid = m; irq_end = e;
    @(negedge clk);
    irq_mid = 1'b0; irq_end = 1'b0;
  endtask

  initial begin
    vec_t       vecs[$];
    logic [7:0] v;
    int         m_shift, m_off, m_s1, m_s2;
    bit         m_mid, m_end;

    // Reset state
    do_reset();
    #1;
    check("reset_iint", {7'd0, iint}, 8'h00);
    check("reset_sound1", sound1, 8'h00);
    check("reset_sound2", sound2, 8'h00);
    check("reset_wdt", {7'd0, wdt_expired}, 8'h00);

    // Vector table: shifter, input ports, unused ports
    in0 = 8'h11; in1 = 8'h22; in2 = 8'h33;
    vecs.push_back('{1'b0, 8'd3, 8'h00, 8'h00});
    vecs.push_back('{1'b1, 8'd4, 8'hAB, 8'h00});
    vecs.push_back('{1'b1, 8'd4, 8'hCD, 8'h00});
    vecs.push_back('{1'b1, 8'd2, 8'h03, 8'h00});
    vecs.push_back('{1'b0, 8'd3, 8'h00, 8'h6D});
    vecs.push_back('{1'b1, 8'd2, 8'h00, 8'h00});
    vecs.push_back('{1'b0, 8'd3, 8'h00, 8'hCD});
    vecs.push_back('{1'b1, 8'd2, 8'h07, 8'h00});
    vecs.push_back('{1'b0, 8'd3, 8'h00, 8'hD5});
    vecs.push_back('{1'b1, 8'd2, 8'h00, 8'h00});
    vecs.push_back('{1'b0, 8'd0, 8'h00, 8'h11});
    vecs.push_back('{1'b0, 8'd1, 8'h00, 8'h22});
    vecs.push_back('{1'b0, 8'd2, 8'h00, 8'h33});
    vecs.push_back('{1'b0, 8'd9, 8'h00, 8'h00});
    foreach (vecs[i]) begin
      if (vecs[i].wr) begin
        do_out(vecs[i].port, vecs[i].val, 1);
      end else begin
        do_in(vecs[i].port, v);
        check($sformatf("vec%0d_in%0d", i, vecs[i].port), v, vecs[i].exp);
      end
    end

    // Long write_n low shifts once: {12,CD} << 4 -> 2C
    do_out(8'd4, 8'h12, 3);
    do_out(8'd2, 8'h04, 1);
    do_in(8'd3, v);
    check("long_write_shift", v, 8'h2C);
    do_out(8'd3, 8'h5A, 1);
    do_out(8'd5, 8'hA5, 1);
    #1;
    check("sound1", sound1, 8'h5A);
    check("sound2", sound2, 8'hA5);

    // Interrupt priority and clear
    pulse_irq(1'b1, 1'b0);
    pulse_irq(1'b0, 1'b1);
    @(negedge clk);
    check("iint_set", {7'd0, iint}, 8'h01);
    do_inta(v, 1'b0);
    check("inta1_vec", v, 8'hD7);
    @(negedge clk);
    check("iint_after_inta1", {7'd0, iint}, 8'h01);
    do_inta(v, 1'b0);
    check("inta2_vec", v, 8'hCF);
    @(negedge clk);
    check("iint_after_inta2", {7'd0, iint}, 8'h00);
    do_inta(v, 1'b0);
    check("inta_idle_vec", v, 8'hFF);

    // Set beats clear on the dbin falling edge
    pulse_irq(1'b1, 1'b0);
    do_inta(v, 1'b1);
    check("inta_race_vec", v, 8'hCF);
    repeat (2) @(negedge clk);
    check("iint_race_kept", {7'd0, iint}, 8'h01);
    do_inta(v, 1'b0);
    check("inta_race_vec2", v, 8'hCF);
    repeat (2) @(negedge clk);
    check("iint_race_cleared", {7'd0, iint}, 8'h00);

    // Watchdog, no kicks: pulses at cycles 16 and 32
    do_reset();
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      check($sformatf("wdt_free_c%0d", k), {7'd0, wdt_expired}, {7'd0, (k % 16) == 0});
      @(negedge clk);
    end
    // Watchdog kicked at cycle 10: pulses at 26 and 42
    do_reset();
    for (int k = 1; k <= 44; k++) begin
      if (k == 10) begin
        status = 8'h10; addr = 8'd6; tb_drv = 8'h00; tb_en = 1'b1; write_n = 1'b0;
      end else begin
        status = 8'h00; tb_en = 1'b0; write_n = 1'b1;
      end
      @(posedge clk); #1;
      check($sformatf("wdt_kick_c%0d", k), {7'd0, wdt_expired},
            {7'd0, (k >= 26) && ((k - 10) % 16 == 0)});
      @(negedge clk);
    end
    status = 8'h00; tb_en = 1'b0; write_n = 1'b1;

    // Randomized I/O and interrupt traffic against a port-level model
    do_reset();
    m_shift = 0; m_off = 0; m_s1 = 0; m_s2 = 0; m_mid = 1'b0; m_end = 1'b0;
    for (int n = 0; n < 300; n++) begin
      int op, port, val, exp;
      op   = $urandom_range(3, 0);
      port = $urandom_range(7, 0);
      val  = $urandom_range(255, 0);
      case (op)
        0: begin
          do_out(port[7:0], val[7:0], $urandom_range(3, 1));
          if (port == 2) m_off = val % 8;
          if (port == 3) m_s1 = val;
          if (port == 4) m_shift = (val * 256) + (m_shift / 256);
          if (port == 5) m_s2 = val;
          #1;
          check("rnd_sound1", sound1, m_s1[7:0]);
          check("rnd_sound2", sound2, m_s2[7:0]);
        end
        1: begin
          in0 = 8'($urandom); in1 = 8'($urandom); in2 = 8'($urandom);
          exp = (port == 0) ? int'(in0) : (port == 1) ? int'(in1) :
                (port == 2) ? int'(in2) :
                (port == 3) ? ((m_shift * (1 << m_off)) / 256) % 256 : 0;
          do_in(port[7:0], v);
          check($sformatf("rnd_in%0d", port), v, exp[7:0]);
        end
        2: begin
          bit pm, pe;
          pm = 1'($urandom); pe = 1'($urandom);
          pulse_irq(pm, pe);
          m_mid = m_mid | pm; m_end = m_end | pe;
        end
        default: begin
          exp = m_end ? 8'hD7 : m_mid ? 8'hCF : 8'hFF;
          do_inta(v, 1'b0);
          check("rnd_inta", v, exp[7:0]);
          if (m_end) m_end = 1'b0; else m_mid = 1'b0;
        end
      endcase
      @(negedge clk);
      check("rnd_iint", {7'd0, iint}, {7'd0, m_mid | m_end});
    end

    // Reset in the middle of an INTA with both flags pending
    do_out(8'd3, 8'h77, 1);
    do_out(8'd5, 8'h88, 1);
    pulse_irq(1'b1, 1'b1);
    @(negedge clk);
    status = 8'h01; dbin = 1'b1;
    #1 check("mid_inta_vec", data, 8'hD7);
    #1 rst_n = 1'b0;
    #1;
    check("rst_iint", {7'd0, iint}, 8'h00);
    check("rst_sound1", sound1, 8'h00);
    check("rst_sound2", sound2, 8'h00);
    n_tests++;
    if (!((data === 8'hzz) || (data === 8'h00))) begin
      n_fail++;
      $display("FAIL rst_bus_released: got %h expected zz", data);
    end
    @(negedge clk);
    dbin = 1'b0;
    @(negedge clk);
    status = 8'h00; rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_iint", {7'd0, iint}, 8'h00);
    do_inta(v, 1'b0);
    check("post_rst_inta", v, 8'hFF);
    in0 = 8'h0F;
    do_in(8'd0, v);
    check("post_rst_in0", v, 8'h0F);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
